// File: rtl/bcd_display_scanner.sv
// Multiplexed 4-digit MM:SS scanner for a common-anode 7-segment display.
// Frame-synchronous value update, dead time, leading-zero blanking, error blink.
module bcd_display_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD_CYC     = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk_in,
   input  logic        RESET_N,
   input  logic [16:1] D_Q,
   input  logic        LOAD,
   input  logic        ERROR,
   input  logic        LZ_EN,
   output logic [4:1]  AN,
   output logic [7:1]  SEG,
   output logic        DP,
   output logic        FRAME_DONE
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYC - 1);
   localparam logic [CW-1:0] FD_PRE     = CW'(REFRESH_DIV - 2);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic {PH_DEAD, PH_ON} phase_t;

   phase_t        phase;
   logic [CW-1:0] cnt;
   logic [1:0]    digit;
   logic [16:1]   pending;
   logic [16:1]   display;
   logic          pend_valid;
   logic [BW-1:0] blink_cnt;
   logic          blink_vis;

   logic [3:0]    nib;
   logic [7:1]    seg_dec;
   logic          show;
   logic          slot_end;
   logic          frame_end;

   always_comb begin
      nib = display[4:1];
      unique case (digit)
         2'd0: nib = display[4:1];
         2'd1: nib = display[8:5];
         2'd2: nib = display[12:9];
         2'd3: nib = display[16:13];
      endcase
   end

   always_comb begin
      seg_dec = 7'b0111111;
      case (nib)
         4'd0: seg_dec = 7'b1000000;
         4'd1: seg_dec = 7'b1111001;
         4'd2: seg_dec = 7'b0100100;
         4'd3: seg_dec = 7'b0110000;
         4'd4: seg_dec = 7'b0011001;
         4'd5: seg_dec = 7'b0010010;
         4'd6: seg_dec = 7'b0000010;
         4'd7: seg_dec = 7'b1111000;
         4'd8: seg_dec = 7'b0000000;
         4'd9: seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;
      endcase
   end

   assign slot_end  = (cnt == SLOT_LAST);
   assign frame_end = slot_end && (digit == 2'd3);
   assign show      = (phase == PH_ON) && blink_vis &&
                      !(digit == 2'd3 && LZ_EN && display[16:13] == 4'd0);

   always_ff @(posedge clk_in or negedge RESET_N) begin
      if (!RESET_N) begin
         phase      <= PH_DEAD;
         cnt        <= '0;
         digit      <= '0;
         pending    <= '0;
         display    <= '0;
         pend_valid <= 1'b0;
         blink_cnt  <= '0;
         blink_vis  <= 1'b1;
         AN         <= '1;
         SEG        <= '1;
         DP         <= 1'b1;
         FRAME_DONE <= 1'b0;
      end else begin
         if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            phase <= PH_DEAD;
         end else begin
            cnt <= cnt + CW'(1);
            if (cnt == DEAD_LAST) phase <= PH_ON;
         end

         // A LOAD coinciding with the display copy re-arms pending for the next frame.
         if (digit == 2'd0 && cnt == '0 && pend_valid) begin
            display    <= pending;
            pend_valid <= LOAD;
         end else if (LOAD) begin
            pend_valid <= 1'b1;
         end
         if (LOAD) pending <= D_Q;

         if (!ERROR) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
         end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_vis <= ~blink_vis;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end

         AN  <= show ? ~(4'b0001 << digit) : '1;
         SEG <= show ? seg_dec : '1;
         DP  <= ~(show && digit == 2'd2);
         // Raised one count early so the registered pulse lands on the slot's last cycle.
         FRAME_DONE <= (digit == 2'd3) && (cnt == FD_PRE);
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner against a time-indexed behavioural model.
module tb_bcd_display_scanner;

   localparam int RD = 8;
   localparam int DC = 2;
   localparam int BF = 2;
   localparam int FR = 4 * RD;

   logic        clk_in = 1'b0;
   logic        RESET_N = 1'b0;
   logic [16:1] D_Q = '0;
   logic        LOAD = 1'b0;
   logic        ERROR = 1'b0;
   logic        LZ_EN = 1'b0;
   logic [4:1]  AN;
   logic [7:1]  SEG;
   logic        DP;
   logic        FRAME_DONE;

   int vectors = 0;
   int miscompares = 0;

   // Model state: idx counts clock edges since reset release.
   int unsigned idx;
   logic [15:0] m_pend, m_disp;
   bit          m_pv;
   int unsigned err_frames;
   logic [12:0] exp_out;

   localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};

   bcd_display_scanner #(.REFRESH_DIV(RD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
      .clk_in(clk_in), .RESET_N(RESET_N), .D_Q(D_Q), .LOAD(LOAD), .ERROR(ERROR),
      .LZ_EN(LZ_EN), .AN(AN), .SEG(SEG), .DP(DP), .FRAME_DONE(FRAME_DONE)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s idx=%0d: got AN/SEG/DP/FD=%b required %b", tag, idx, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      if (n > 4'd9) return 7'h3F;
      return tab[n];
   endfunction

   task automatic model_reset();
      idx = 0; m_pend = '0; m_disp = '0; m_pv = 0; err_frames = 0;
   endtask

   // Expected outputs after this edge come from the model state before it.
   task automatic model_step();
      int unsigned c, d;
      bit vis, show;
      logic [3:0] nib;
      logic [3:0] an_e;
      c = idx % RD;
      d = (idx / RD) % 4;
      vis = ((err_frames / BF) % 2) == 0;
      nib = m_disp[4*d +: 4];
      show = (c >= DC) && vis && !(d == 3 && LZ_EN && m_disp[15:12] == 4'd0);
      an_e = 4'hF;
      if (show) an_e[d] = 1'b0;
      exp_out = {an_e, show ? seg_of(nib) : 7'h7F, !(show && d == 2),
                 ((idx + 1) % FR) == FR - 1};
      if (idx % FR == 0 && m_pv) begin
         m_disp = m_pend;
         m_pv = 0;
      end
      if (LOAD) begin
         m_pend = D_Q;
         m_pv = 1;
      end
      if (!ERROR) err_frames = 0;
      else if (idx % FR == FR - 1) err_frames++;
      idx++;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      check(tag, {AN, SEG, DP, FRAME_DONE}, exp_out);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic load(input string tag, input logic [15:0] v);
      D_Q = v; LOAD = 1'b1;
      cycle(tag);
      LOAD = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      check("reset", {AN, SEG, DP, FRAME_DONE}, BLANK);
      @(negedge clk_in);
      check("reset_hold", {AN, SEG, DP, FRAME_DONE}, BLANK);
      RESET_N = 1'b1;

      run("idle", 2 * FR);

      run("pre_1020", 11);
      load("ld_1020", 16'h1020);
      run("show_1020", 3 * FR);

      LZ_EN = 1'b1;
      load("ld_0930", 16'h0930);
      run("lz_on", 2 * FR);
      LZ_EN = 1'b0;
      run("lz_off", 2 * FR);

      load("ld_5555", 16'h5555);
      while (idx % FR != 0) cycle("align");
      ERROR = 1'b1;
      run("blink", 6 * FR + 5);
      ERROR = 1'b0;
      run("blink_off", 2 * FR);

      load("ld_4a3f", 16'h4A3F);
      run("invalid", 2 * FR);

      while (idx % FR != 3) cycle("align2");
      load("ld_0100", 16'h0100);
      run("gap", 4);
      load("ld_0200", 16'h0200);
      run("show_0200", 2 * FR);

      for (int i = 0; i < 2 * FR && !(((idx / RD) % 4) == 2 && (idx % RD) == 5); i++)
         cycle("seek_d2");
      #2 RESET_N = 1'b0;
      #1 check("async_rst", {AN, SEG, DP, FRAME_DONE}, BLANK);
      @(negedge clk_in);
      check("rst_held", {AN, SEG, DP, FRAME_DONE}, BLANK);
      model_reset();
      RESET_N = 1'b1;
      run("post_rst", 2 * FR);

      for (int i = 0; i < 1500; i++) begin
         LOAD = ($urandom_range(0, 19) == 0);
         if (LOAD) D_Q = 16'($urandom);
         if ($urandom_range(0, 99) == 0) LZ_EN = ~LZ_EN;
         if ($urandom_range(0, 149) == 0) ERROR = ~ERROR;
         cycle("random");
      end
      LOAD = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running required done");
      $fatal(1);
   end

endmodule
